// File: rtl/combo_lock_controller_pkg.sv
// Shared definitions for the combination lock controller.
// State encodings and default build parameters.
// Imported by the controller top and its sub-modules.
package combo_lock_controller_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    PROGRAM = 2'd2,
    ALARM   = 2'd3
  } state_t;

  localparam int          DEF_DIGITS         = 4;
  localparam int          DEF_DIGIT_W        = 4;
  localparam int          DEF_MAX_TRIES      = 3;
  localparam int          DEF_LOCKOUT_CYCLES = 16;
  localparam logic [15:0] DEF_RESET_CODE     = 16'h1234;

endpackage

// File: rtl/combo_lock_controller_lockout_timer.sv
// Lockout timer: counts LOCKOUT_CYCLES cycles after a start pulse.
// Latency: done pulses LOCKOUT_CYCLES cycles after the cycle start was high.
// No backpressure; a start while running restarts the count.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic start,
  output logic done
);

  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

  logic          running;
  logic [CW-1:0] cnt;

  // Terminal count reached in the last cycle of the lockout window.
  assign done = running && (cnt == CW'(LOCKOUT_CYCLES - 1));

  // Free-running count from 0 to LOCKOUT_CYCLES-1 while armed.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (done) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/combo_lock_controller.sv
// Combination lock sequencer: digit entry, compare, reprogram, lockout alarm.
// Latency: every output is a flop; a pulse in cycle n shows up in cycle n+1.
// No backpressure; pulses are consumed in the cycle they arrive.
module combo_lock_controller
  import combo_lock_controller_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = DEF_RESET_CODE
) (
  input  logic                               Clock,
  input  logic                               Resetn,
  input  logic                               enter_pulse,
  input  logic                               set_pulse,
  input  logic [DIGIT_W-1:0]                 digit,
  output logic                               unlocked,
  output logic                               programming,
  output logic                               alarm,
  output logic                               err_pulse,
  output logic [$clog2(DIGITS+1)-1:0]        digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int TW     = $clog2(MAX_TRIES + 1);

  state_t                    state_q, state_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic [CODE_W-1:0]         stage_q, stage_d;
  logic [CODE_W+DIGIT_W-1:0] stage_ext;
  logic                      mism_q, mism_d;
  logic                      mism_now;
  logic [CW-1:0]             count_d;
  logic [TW-1:0]             tries_d;
  logic                      err_d;
  logic                      last_digit;
  logic [DIGIT_W-1:0]        exp_digit;
  logic                      tmr_start;
  logic                      tmr_done;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .Clock (Clock),
    .Resetn(Resetn),
    .start (tmr_start),
    .done  (tmr_done)
  );

  // First digit entered is the most-significant digit of the code.
  assign stage_ext  = {stage_q, digit};
  assign last_digit = (digit_count == CW'(DIGITS - 1));

  // Select the stored code digit that the next entry is compared against.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_count == CW'(i)) exp_digit = code_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  // Next-state and datapath decisions for every state.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    stage_d   = stage_q;
    mism_d    = mism_q;
    count_d   = digit_count;
    tries_d   = tries_left;
    err_d     = 1'b0;
    tmr_start = 1'b0;
    mism_now  = mism_q | (digit != exp_digit);
    unique case (state_q)
      LOCKED: begin
        if (enter_pulse) begin
          if (last_digit) begin
            count_d = '0;
            mism_d  = 1'b0;
            if (!mism_now) begin
              state_d = OPEN;
              tries_d = TW'(MAX_TRIES);
            end else if (tries_left > TW'(1)) begin
              tries_d = tries_left - TW'(1);
              err_d   = 1'b1;
            end else begin
              // Final allowed failure: fail count reaches MAX_TRIES.
              state_d   = ALARM;
              tries_d   = '0;
              tmr_start = 1'b1;
            end
          end else begin
            count_d = digit_count + CW'(1);
            mism_d  = mism_now;
          end
        end
      end
      OPEN: begin
        // set_pulse has priority over a simultaneous enter_pulse.
        if (set_pulse) begin
          state_d = PROGRAM;
          count_d = '0;
        end else if (enter_pulse) begin
          state_d = LOCKED;
          count_d = '0;
        end
      end
      PROGRAM: begin
        if (set_pulse) begin
          state_d = OPEN;
          count_d = '0;
        end else if (enter_pulse) begin
          stage_d = stage_ext[CODE_W-1:0];
          if (last_digit) begin
            code_d  = stage_ext[CODE_W-1:0];
            state_d = LOCKED;
            count_d = '0;
          end else begin
            count_d = digit_count + CW'(1);
          end
        end
      end
      ALARM: begin
        if (tmr_done) begin
          state_d = LOCKED;
          tries_d = TW'(MAX_TRIES);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= LOCKED;
      code_q      <= RESET_CODE;
      stage_q     <= '0;
      mism_q      <= 1'b0;
      digit_count <= '0;
      tries_left  <= TW'(MAX_TRIES);
      err_pulse   <= 1'b0;
      unlocked    <= 1'b0;
      programming <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      stage_q     <= stage_d;
      mism_q      <= mism_d;
      digit_count <= count_d;
      tries_left  <= tries_d;
      err_pulse   <= err_d;
      unlocked    <= (state_d == OPEN);
      programming <= (state_d == PROGRAM);
      alarm       <= (state_d == ALARM);
    end
  end

endmodule

// File: tb/tb_combo_lock_controller.sv
// Bench for combo_lock_controller: vector table, directed corner cases, random run.
module tb_combo_lock_controller;

  localparam int DIGITS    = 4;
  localparam int DIGIT_W   = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT   = 16;

  localparam int M_LOCK  = 10;
  localparam int M_OPEN  = 11;
  localparam int M_PROG  = 12;
  localparam int M_ALARM = 13;

  logic               Clock = 1'b0;
  logic               Resetn;
  logic               enter_pulse;
  logic               set_pulse;
  logic [DIGIT_W-1:0] digit;
  logic               unlocked;
  logic               programming;
  logic               alarm;
  logic               err_pulse;
  logic [2:0]         digit_count;
  logic [1:0]         tries_left;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_mode;
  int m_buf[$];
  int m_code[DIGITS];
  int m_fails;
  int m_left;
  bit m_err;

  typedef struct {
    bit e; bit s; int d;
    bit u; bit p; bit a; bit er; int cnt; int tl;
  } vec_t;
  vec_t tbl[25];

  combo_lock_controller #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYCLES(LOCKOUT), .RESET_CODE(16'h1234)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .enter_pulse(enter_pulse), .set_pulse(set_pulse),
    .digit(digit), .unlocked(unlocked), .programming(programming), .alarm(alarm),
    .err_pulse(err_pulse), .digit_count(digit_count), .tries_left(tries_left)
  );

  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] dut_outs();
    return {unlocked, programming, alarm, err_pulse, digit_count, tries_left};
  endfunction

  function automatic logic [8:0] pack(bit u, bit p, bit a, bit e, int cnt, int tl);
    return {u, p, a, e, 3'(cnt), 2'(tl)};
  endfunction

  function automatic logic [8:0] model_outs();
    return pack(m_mode == M_OPEN, m_mode == M_PROG, m_mode == M_ALARM, m_err,
                m_buf.size(), MAX_TRIES - m_fails);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_LOCK;
    m_buf.delete();
    m_code  = '{1, 2, 3, 4};
    m_fails = 0;
    m_left  = 0;
    m_err   = 1'b0;
  endtask

  // Behavioural rules: digits collected in a queue, compared as a whole list.
  task automatic model_step(input bit e, input bit s, input int d);
    bit same;
    m_err = 1'b0;
    case (m_mode)
      M_LOCK: if (e) begin
        m_buf.push_back(d);
        if (m_buf.size() == DIGITS) begin
          same = 1'b1;
          for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_code[i]) same = 1'b0;
          m_buf.delete();
          if (same) begin
            m_mode = M_OPEN; m_fails = 0;
          end else begin
            m_fails++;
            if (m_fails == MAX_TRIES) begin
              m_mode = M_ALARM; m_left = LOCKOUT;
            end else m_err = 1'b1;
          end
        end
      end
      M_OPEN: begin
        if (s) begin m_mode = M_PROG; m_buf.delete(); end
        else if (e) m_mode = M_LOCK;
      end
      M_PROG: begin
        if (s) begin m_mode = M_OPEN; m_buf.delete(); end
        else if (e) begin
          m_buf.push_back(d);
          if (m_buf.size() == DIGITS) begin
            for (int i = 0; i < DIGITS; i++) m_code[i] = m_buf[i];
            m_buf.delete();
            m_mode = M_LOCK;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_LOCK; m_fails = 0; end
      end
    endcase
  endtask

  task automatic apply(input bit e, input bit s, input int d);
    @(negedge Clock);
    enter_pulse = e;
    set_pulse   = s;
    digit       = DIGIT_W'(d);
    @(posedge Clock);
    model_step(e, s, d);
    #1;
    check("model", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    apply(1, 0, a); apply(1, 0, b); apply(1, 0, c); apply(1, 0, d);
  endtask

  initial begin
    int alarm_cycles;
    int d;
    bit e, s;

    //            e  s  d   u  p  a  er cnt tl
    tbl[0]  = '{1, 0, 1,  0, 0, 0, 0, 1, 3};
    tbl[1]  = '{1, 0, 2,  0, 0, 0, 0, 2, 3};
    tbl[2]  = '{1, 0, 3,  0, 0, 0, 0, 3, 3};
    tbl[3]  = '{1, 0, 4,  1, 0, 0, 0, 0, 3};
    tbl[4]  = '{0, 0, 0,  1, 0, 0, 0, 0, 3};
    tbl[5]  = '{1, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[6]  = '{1, 0, 1,  0, 0, 0, 0, 1, 3};
    tbl[7]  = '{1, 0, 2,  0, 0, 0, 0, 2, 3};
    tbl[8]  = '{1, 0, 3,  0, 0, 0, 0, 3, 3};
    tbl[9]  = '{1, 0, 5,  0, 0, 0, 1, 0, 2};
    tbl[10] = '{0, 0, 0,  0, 0, 0, 0, 0, 2};
    tbl[11] = '{0, 1, 0,  0, 0, 0, 0, 0, 2};
    tbl[12] = '{1, 0, 1,  0, 0, 0, 0, 1, 2};
    tbl[13] = '{1, 0, 2,  0, 0, 0, 0, 2, 2};
    tbl[14] = '{1, 0, 3,  0, 0, 0, 0, 3, 2};
    tbl[15] = '{1, 0, 4,  1, 0, 0, 0, 0, 3};
    tbl[16] = '{1, 1, 7,  0, 1, 0, 0, 0, 3};
    tbl[17] = '{1, 0, 9,  0, 1, 0, 0, 1, 3};
    tbl[18] = '{1, 0, 8,  0, 1, 0, 0, 2, 3};
    tbl[19] = '{0, 1, 0,  1, 0, 0, 0, 0, 3};
    tbl[20] = '{1, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[21] = '{1, 0, 1,  0, 0, 0, 0, 1, 3};
    tbl[22] = '{1, 0, 2,  0, 0, 0, 0, 2, 3};
    tbl[23] = '{1, 0, 3,  0, 0, 0, 0, 3, 3};
    tbl[24] = '{1, 0, 4,  1, 0, 0, 0, 0, 3};

    Resetn = 1'b0; enter_pulse = 1'b0; set_pulse = 1'b0; digit = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    check("reset", 32'(dut_outs()), 32'(pack(0, 0, 0, 0, 0, 3)));
    @(negedge Clock);
    Resetn = 1'b1;

    // Vector table: correct entry, wrong entry, ignore set, abort, priority.
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].e, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d", i), 32'(dut_outs()),
            32'(pack(tbl[i].u, tbl[i].p, tbl[i].a, tbl[i].er, tbl[i].cnt, tbl[i].tl)));
    end

    // Alarm: three wrong entries, then exact alarm length with inputs ignored.
    apply(1, 0, 0);
    for (int t = 0; t < MAX_TRIES; t++) enter_code(1, 2, 3, 5);
    check("alarm_enter", 32'(alarm), 32'd1);
    check("alarm_no_err", 32'(err_pulse), 32'd0);
    alarm_cycles = 1;
    for (int k = 0; k < 40 && alarm === 1'b1; k++) begin
      apply(1, (k % 3) == 0, 9);
      check("alarm_count", 32'(digit_count), 32'd0);
      if (alarm === 1'b1) alarm_cycles++;
    end
    check("alarm_len", 32'(alarm_cycles), 32'(LOCKOUT));
    check("alarm_exit_tries", 32'(tries_left), 32'(MAX_TRIES));

    // Reprogramming to 9876.
    enter_code(1, 2, 3, 4);
    check("open_again", 32'(unlocked), 32'd1);
    apply(0, 1, 0);
    enter_code(9, 8, 7, 6);
    check("prog_commit", 32'({unlocked, programming}), 32'd0);
    enter_code(1, 2, 3, 4);
    check("old_code_fails", 32'(err_pulse), 32'd1);
    enter_code(9, 8, 7, 6);
    check("new_code_opens", 32'(unlocked), 32'd1);

    // Asynchronous reset in the middle of programming.
    apply(0, 1, 0);
    apply(1, 0, 9);
    apply(1, 0, 8);
    check("mid_prog", 32'({programming, digit_count}), 32'({1'b1, 3'd2}));
    @(negedge Clock);
    enter_pulse = 1'b0; set_pulse = 1'b0;
    Resetn = 1'b0;
    #2;
    check("async_reset", 32'(dut_outs()), 32'(pack(0, 0, 0, 0, 0, 3)));
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    enter_code(1, 2, 3, 4);
    check("reset_code", 32'(unlocked), 32'd1);

    // Random traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      e = ($urandom_range(0, 99) < 40);
      s = ($urandom_range(0, 99) < 8);
      if (m_mode == M_LOCK && $urandom_range(0, 9) < 7) d = m_code[m_buf.size()];
      else d = $urandom_range(0, 15);
      apply(e, s, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
